simd_perm_network: RTL and testbench
====================================

# simd_perm_network

Register-based 32-lane SIMD permutation unit: 32 words of DATA_WIDTH bits, arranged as 4 rows × 8 lanes. It holds two data buffers (ping-pong, selected by `io_addr`) and one index table. On command it gathers one buffer through the index table into an output register, which can then be row-rotated. It sits between a vector load path and a vector consumer.

## Interface
- DATA_WIDTH, 64, bits per word.
- NUM_ROWS, 4, rows per vector.
- NUM_LANES, 8, lanes per row. Flat lane number n = row*NUM_LANES + lane, range 0..31.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- io_in_valid  in  1  write `io_in_data` into the target chosen by `io_sel_idx_val`/`io_addr`.
- io_sel_idx_val  in  1  write target: 1 = index table, 0 = data buffer `io_addr`.
- io_addr  in  1  data buffer select (0/1) for writes.
- io_in_data_R_L  in  DATA_WIDTH each (R 0..3, L 0..7)  input vector; flat lane n = R*8+L.
- io_rotate  in  1  rotate output register by one row.
- io_out_valid  in  1  capture permuted vector into output register.
- io_sel_out  in  1  data buffer (0/1) to permute on capture.
- io_out_data_R_L  out  DATA_WIDTH each  output register contents, flat lane n = R*8+L.

## Operation
- State: BUF0[32], BUF1[32] (DATA_WIDTH each); IDX[32] (5 bits each); OUT[32] (DATA_WIDTH each).
- Write: when io_in_valid=1 and io_sel_idx_val=0, BUFio_addr[n] <= in[n] for all n.
- Write: when io_in_valid=1 and io_sel_idx_val=1, IDX[n] <= in[n][4:0] for all n. Upper bits are ignored. io_addr is ignored for index writes.
- Capture: when io_out_valid=1, OUT[n] <= BUFio_sel_out[IDX[n]] for all n. This is a full gather: duplicates are allowed and unreferenced lanes are dropped.
- Rotate: when io_rotate=1 and io_out_valid=0, OUT row r <= OUT row (r+1) mod 4 for all lanes. Row 0 receives old row 1; row 3 receives old row 0.
- Priority: capture beats rotate. Rotate is ignored in a capture cycle.
- Writes, captures and rotates are independent and may all occur in the same cycle.
- io_out_data is always OUT. There is no output handshake.
- No FSM; behaviour is purely per-cycle command driven.

## Timing
- Reset (synchronous): BUF0, BUF1 and OUT cleared to 0. IDX[n] = n (identity). io_out_data reads 0 from the cycle after the reset edge.
- Write latency 1: data written at edge k is usable by a capture issued in cycle k+1.
- Same-cycle write and capture: the capture uses pre-edge contents (old buffer and old IDX), even if the write targets the same buffer or the index table.
- Capture latency 1: io_out_valid high in cycle k makes io_out_data show the result after edge k.
- Each rotate cycle shifts by exactly one row. Four consecutive rotates return OUT to its original contents.
- Reset in the middle of a command sequence: reset wins over every command in that cycle, and the state is reinitialised.

## Configuration
- SIMD_PERM_ROTATE_EN defined: io_rotate behaves as specified.
- SIMD_PERM_ROTATE_EN undefined:
  - io_rotate is ignored and OUT changes only on capture or reset.
  - The rotate mux is not synthesised.
  - The port remains present.

## Test plan
- Reset, then capture with io_sel_out=0 → all 32 io_out_data words = 0 and the default IDX is identity.
- Write BUF0[n]=n+100 (identity IDX), capture sel_out=0 → out[n]=n+100. Write BUF1[n]=0xFFFF0000+n, capture sel_out=1 → out[n]=0xFFFF0000+n, and BUF0 is unchanged.
- Write IDX[n]=31-n (upper bits set to 0xDEAD…), capture BUF0 → out[n]=131-n. Then IDX all 5 → every lane = 105.
- After the identity capture of BUF0, apply 1 rotate → out row 0 = 108..115 and row 3 = 100..107. After 4 rotates the original is restored. With the macro undefined, the output is unchanged.
- Same cycle: write IDX reverse plus capture → output uses the old identity IDX. The next capture uses the reversed IDX. Same cycle: rotate plus capture → capture result, not rotated.
- Assert reset during a cycle with in_valid, out_valid and rotate all high → OUT=0 and IDX is identity afterwards.

Source files
------------

// File: rtl/simd_perm_network.sv
// 32-lane (4 rows x 8 lanes) SIMD gather unit with ping-pong data buffers and an index table.
// Optional one-row output rotate is enabled by defining SIMD_PERM_ROTATE_EN.
module simd_perm_network #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_ROWS   = 4,
    parameter int unsigned NUM_LANES  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_in_valid,
    input  logic                  io_sel_idx_val,
    input  logic                  io_addr,
    input  logic [DATA_WIDTH-1:0]
        io_in_data_0_0, io_in_data_0_1, io_in_data_0_2, io_in_data_0_3,
        io_in_data_0_4, io_in_data_0_5, io_in_data_0_6, io_in_data_0_7,
        io_in_data_1_0, io_in_data_1_1, io_in_data_1_2, io_in_data_1_3,
        io_in_data_1_4, io_in_data_1_5, io_in_data_1_6, io_in_data_1_7,
        io_in_data_2_0, io_in_data_2_1, io_in_data_2_2, io_in_data_2_3,
        io_in_data_2_4, io_in_data_2_5, io_in_data_2_6, io_in_data_2_7,
        io_in_data_3_0, io_in_data_3_1, io_in_data_3_2, io_in_data_3_3,
        io_in_data_3_4, io_in_data_3_5, io_in_data_3_6, io_in_data_3_7,
    input  logic                  io_rotate,
    input  logic                  io_out_valid,
    input  logic                  io_sel_out,
    output logic [DATA_WIDTH-1:0]
        io_out_data_0_0, io_out_data_0_1, io_out_data_0_2, io_out_data_0_3,
        io_out_data_0_4, io_out_data_0_5, io_out_data_0_6, io_out_data_0_7,
        io_out_data_1_0, io_out_data_1_1, io_out_data_1_2, io_out_data_1_3,
        io_out_data_1_4, io_out_data_1_5, io_out_data_1_6, io_out_data_1_7,
        io_out_data_2_0, io_out_data_2_1, io_out_data_2_2, io_out_data_2_3,
        io_out_data_2_4, io_out_data_2_5, io_out_data_2_6, io_out_data_2_7,
        io_out_data_3_0, io_out_data_3_1, io_out_data_3_2, io_out_data_3_3,
        io_out_data_3_4, io_out_data_3_5, io_out_data_3_6, io_out_data_3_7
);

    localparam int unsigned NUM_WORDS = NUM_ROWS * NUM_LANES;
    localparam int unsigned IDX_W     = $clog2(NUM_WORDS);

    // Flat lane n = row*NUM_LANES + lane; lane 0 sits at the lowest array index.
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] in_flat;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] buf0_q, buf1_q, out_q, out_d;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] src_buf, gather;
    logic [NUM_WORDS-1:0][IDX_W-1:0]      idx_q;

    assign in_flat = {
        io_in_data_3_7, io_in_data_3_6, io_in_data_3_5, io_in_data_3_4,
        io_in_data_3_3, io_in_data_3_2, io_in_data_3_1, io_in_data_3_0,
        io_in_data_2_7, io_in_data_2_6, io_in_data_2_5, io_in_data_2_4,
        io_in_data_2_3, io_in_data_2_2, io_in_data_2_1, io_in_data_2_0,
        io_in_data_1_7, io_in_data_1_6, io_in_data_1_5, io_in_data_1_4,
        io_in_data_1_3, io_in_data_1_2, io_in_data_1_1, io_in_data_1_0,
        io_in_data_0_7, io_in_data_0_6, io_in_data_0_5, io_in_data_0_4,
        io_in_data_0_3, io_in_data_0_2, io_in_data_0_1, io_in_data_0_0
    };

    assign {
        io_out_data_3_7, io_out_data_3_6, io_out_data_3_5, io_out_data_3_4,
        io_out_data_3_3, io_out_data_3_2, io_out_data_3_1, io_out_data_3_0,
        io_out_data_2_7, io_out_data_2_6, io_out_data_2_5, io_out_data_2_4,
        io_out_data_2_3, io_out_data_2_2, io_out_data_2_1, io_out_data_2_0,
        io_out_data_1_7, io_out_data_1_6, io_out_data_1_5, io_out_data_1_4,
        io_out_data_1_3, io_out_data_1_2, io_out_data_1_1, io_out_data_1_0,
        io_out_data_0_7, io_out_data_0_6, io_out_data_0_5, io_out_data_0_4,
        io_out_data_0_3, io_out_data_0_2, io_out_data_0_1, io_out_data_0_0
    } = out_q;

    // Gather reads pre-edge buffer and index state, so same-cycle writes are not visible.
    always_comb begin
        src_buf = io_sel_out ? buf1_q : buf0_q;
        gather  = '0;
        for (int n = 0; n < NUM_WORDS; n++) begin
            gather[n] = src_buf[idx_q[n]];
        end
    end

`ifdef SIMD_PERM_ROTATE_EN
    always_comb begin
        out_d = out_q;
        if (io_out_valid) begin
            out_d = gather;
        end else if (io_rotate) begin
            // Row r takes row r+1; old row 0 wraps into the top row.
            out_d = {out_q[NUM_LANES-1:0], out_q[NUM_WORDS-1:NUM_LANES]};
        end
    end
`else
    logic unused_rotate;
    assign unused_rotate = io_rotate;

    always_comb begin
        out_d = out_q;
        if (io_out_valid) begin
            out_d = gather;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            buf0_q <= '0;
            buf1_q <= '0;
            out_q  <= '0;
            for (int n = 0; n < NUM_WORDS; n++) begin
                idx_q[n] <= IDX_W'(n);
            end
        end else begin
            out_q <= out_d;
            if (io_in_valid) begin
                if (io_sel_idx_val) begin
                    for (int n = 0; n < NUM_WORDS; n++) begin
                        idx_q[n] <= in_flat[n][IDX_W-1:0];
                    end
                end else if (io_addr) begin
                    buf1_q <= in_flat;
                end else begin
                    buf0_q <= in_flat;
                end
            end
        end
    end

endmodule

// File: tb/tb_simd_perm_network.sv
// Directed self-checking bench for simd_perm_network; expectations follow SIMD_PERM_ROTATE_EN.
module tb_simd_perm_network;

    logic        clock = 1'b0;
    logic        reset, io_in_valid, io_sel_idx_val, io_addr;
    logic        io_rotate, io_out_valid, io_sel_out;
    logic [63:0] di [32];
    logic [63:0] dq [32];
    logic [63:0] exp_w [32];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clock = ~clock;

    simd_perm_network dut (
        .clock(clock), .reset(reset), .io_in_valid(io_in_valid),
        .io_sel_idx_val(io_sel_idx_val), .io_addr(io_addr), .io_rotate(io_rotate),
        .io_out_valid(io_out_valid), .io_sel_out(io_sel_out),
        .io_in_data_0_0(di[0]),   .io_in_data_0_1(di[1]),
        .io_in_data_0_2(di[2]),   .io_in_data_0_3(di[3]),
        .io_in_data_0_4(di[4]),   .io_in_data_0_5(di[5]),
        .io_in_data_0_6(di[6]),   .io_in_data_0_7(di[7]),
        .io_in_data_1_0(di[8]),   .io_in_data_1_1(di[9]),
        .io_in_data_1_2(di[10]),  .io_in_data_1_3(di[11]),
        .io_in_data_1_4(di[12]),  .io_in_data_1_5(di[13]),
        .io_in_data_1_6(di[14]),  .io_in_data_1_7(di[15]),
        .io_in_data_2_0(di[16]),  .io_in_data_2_1(di[17]),
        .io_in_data_2_2(di[18]),  .io_in_data_2_3(di[19]),
        .io_in_data_2_4(di[20]),  .io_in_data_2_5(di[21]),
        .io_in_data_2_6(di[22]),  .io_in_data_2_7(di[23]),
        .io_in_data_3_0(di[24]),  .io_in_data_3_1(di[25]),
        .io_in_data_3_2(di[26]),  .io_in_data_3_3(di[27]),
        .io_in_data_3_4(di[28]),  .io_in_data_3_5(di[29]),
        .io_in_data_3_6(di[30]),  .io_in_data_3_7(di[31]),
        .io_out_data_0_0(dq[0]),  .io_out_data_0_1(dq[1]),
        .io_out_data_0_2(dq[2]),  .io_out_data_0_3(dq[3]),
        .io_out_data_0_4(dq[4]),  .io_out_data_0_5(dq[5]),
        .io_out_data_0_6(dq[6]),  .io_out_data_0_7(dq[7]),
        .io_out_data_1_0(dq[8]),  .io_out_data_1_1(dq[9]),
        .io_out_data_1_2(dq[10]), .io_out_data_1_3(dq[11]),
        .io_out_data_1_4(dq[12]), .io_out_data_1_5(dq[13]),
        .io_out_data_1_6(dq[14]), .io_out_data_1_7(dq[15]),
        .io_out_data_2_0(dq[16]), .io_out_data_2_1(dq[17]),
        .io_out_data_2_2(dq[18]), .io_out_data_2_3(dq[19]),
        .io_out_data_2_4(dq[20]), .io_out_data_2_5(dq[21]),
        .io_out_data_2_6(dq[22]), .io_out_data_2_7(dq[23]),
        .io_out_data_3_0(dq[24]), .io_out_data_3_1(dq[25]),
        .io_out_data_3_2(dq[26]), .io_out_data_3_3(dq[27]),
        .io_out_data_3_4(dq[28]), .io_out_data_3_5(dq[29]),
        .io_out_data_3_6(dq[30]), .io_out_data_3_7(dq[31])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_out(input string tag);
        for (int n = 0; n < 32; n++) begin
            check($sformatf("%s[%0d]", tag, n), dq[n], exp_w[n]);
        end
    endtask

    task automatic idle();
        reset = 0; io_in_valid = 0; io_sel_idx_val = 0; io_addr = 0;
        io_rotate = 0; io_out_valid = 0; io_sel_out = 0;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic capture(input logic sel);
        io_out_valid = 1; io_sel_out = sel;
        cycle();
    endtask

    initial begin
        idle();
        // Reset asserted alongside every command.
        reset = 1; io_in_valid = 1; io_out_valid = 1; io_rotate = 1;
        for (int n = 0; n < 32; n++) di[n] = 64'h55;
        cycle();
        for (int n = 0; n < 32; n++) exp_w[n] = 64'd0;
        check_out("reset");
        capture(1'b0);
        check_out("cap_zero");

        // BUF0 = n+100, BUF1 = 0xFFFF0000+n through identity IDX.
        for (int n = 0; n < 32; n++) di[n] = 64'(n + 100);
        io_in_valid = 1; io_addr = 0;
        cycle();
        capture(1'b0);
        for (int n = 0; n < 32; n++) exp_w[n] = 64'(n + 100);
        check_out("buf0_ident");
        for (int n = 0; n < 32; n++) di[n] = 64'hFFFF_0000 + 64'(n);
        io_in_valid = 1; io_addr = 1;
        cycle();
        capture(1'b1);
        for (int n = 0; n < 32; n++) exp_w[n] = 64'hFFFF_0000 + 64'(n);
        check_out("buf1_ident");
        capture(1'b0);
        for (int n = 0; n < 32; n++) exp_w[n] = 64'(n + 100);
        check_out("buf0_kept");

        // One rotate, then three more to come back to the start.
        io_rotate = 1;
        cycle();
`ifdef SIMD_PERM_ROTATE_EN
        for (int n = 0; n < 32; n++) exp_w[n] = 64'(((n + 8) % 32) + 100);
        check("rot1_row0_lane0", dq[0], 64'd108);
        check("rot1_row3_lane0", dq[24], 64'd100);
`endif
        check_out("rot1");
        for (int k = 0; k < 3; k++) begin
            io_rotate = 1;
            cycle();
        end
        for (int n = 0; n < 32; n++) exp_w[n] = 64'(n + 100);
        check_out("rot4");

        // Reverse IDX written in the same cycle as a capture: old identity IDX applies.
        for (int n = 0; n < 32; n++) di[n] = 64'hDEAD_BEEF_0000_0000 | 64'(31 - n);
        io_in_valid = 1; io_sel_idx_val = 1; io_addr = 1;
        io_out_valid = 1; io_sel_out = 0;
        cycle();
        check_out("idx_same_cycle");
        capture(1'b0);
        for (int n = 0; n < 32; n++) exp_w[n] = 64'(131 - n);
        check_out("idx_rev");

        // Rotate together with capture: capture wins.
        io_rotate = 1;
        capture(1'b1);
        for (int n = 0; n < 32; n++) exp_w[n] = 64'hFFFF_0000 + 64'(31 - n);
        check_out("cap_over_rot");

        // All lanes point at word 5.
        for (int n = 0; n < 32; n++) di[n] = 64'hDEAD_0000_0000_0005;
        io_in_valid = 1; io_sel_idx_val = 1;
        cycle();
        capture(1'b0);
        for (int n = 0; n < 32; n++) exp_w[n] = 64'd105;
        check_out("idx_all5");

        // Buffer write in the same cycle as a capture of that buffer sees old data.
        for (int n = 0; n < 32; n++) di[n] = 64'(n + 200);
        io_in_valid = 1; io_addr = 0;
        capture(1'b0);
        check_out("buf_same_cycle");
        capture(1'b0);
        for (int n = 0; n < 32; n++) exp_w[n] = 64'd205;
        check_out("buf_new");

        // Mid-sequence reset with write/capture/rotate all active.
        for (int n = 0; n < 32; n++) di[n] = 64'd3;
        reset = 1; io_in_valid = 1; io_sel_idx_val = 1;
        io_out_valid = 1; io_rotate = 1;
        cycle();
        for (int n = 0; n < 32; n++) exp_w[n] = 64'd0;
        check_out("mid_reset");
        capture(1'b1);
        check_out("buf1_cleared");
        for (int n = 0; n < 32; n++) di[n] = 64'(n + 300);
        io_in_valid = 1; io_addr = 0;
        cycle();
        capture(1'b0);
        for (int n = 0; n < 32; n++) exp_w[n] = 64'(n + 300);
        check_out("idx_restored");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
